// File: rtl/chan_rec_pkg.sv
// Shared widths, record layout and byte-index encodings for the channel record receiver.
package chan_rec_pkg;

  localparam int ADDR_W = 22;
  localparam int FRAC_W = 8;
  localparam int VOL_W  = 6;
  localparam int REC_W  = ADDR_W + FRAC_W + VOL_W + VOL_W;

  typedef enum logic [1:0] {
    BYTE_FIRST  = 2'd0,
    BYTE_SECOND = 2'd1,
    BYTE_THIRD  = 2'd2
  } byte_idx_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [FRAC_W-1:0] frac;
    logic [VOL_W-1:0]  vol_l;
    logic [VOL_W-1:0]  vol_r;
  } rec_t;

endpackage

// File: rtl/rec_fifo.sv
// Show-ahead record FIFO; a push while full is taken only when a pop frees a slot in the same cycle.
module rec_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNTW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads zero while empty so stale storage never shows on the outputs.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chan_rec_rx.sv
// Assembles mix and address byte triples from the fetch engine into channel records and queues them.
module chan_rec_rx
  import chan_rec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_stb_addr,
  input  logic              in_stb_mix,
  input  logic              sync_stb,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [FRAC_W-1:0] rec_frac,
  output logic [VOL_W-1:0]  rec_vol_l,
  output logic [VOL_W-1:0]  rec_vol_r,
  output logic [CNTW-1:0]   rec_count,
  output logic              ovf,
  output logic              seq_err,
  input  logic              err_clr
);

  byte_idx_t         mix_idx, nxt_mix_idx;
  byte_idx_t         addr_idx, nxt_addr_idx;
  logic              mix_done, nxt_mix_done;
  logic [FRAC_W-1:0] frac, nxt_frac;
  logic [VOL_W-1:0]  vol_l, nxt_vol_l;
  logic [VOL_W-1:0]  vol_r, nxt_vol_r;
  logic [5:0]        addr_hi, nxt_addr_hi;
  logic [7:0]        addr_mid, nxt_addr_mid;
  logic              push;
  logic              seq_err_set;
  logic              ovf_set;
  logic              fifo_full;
  logic              fifo_empty;
  rec_t              push_rec;
  rec_t              head_rec;

  // The lo byte goes straight into the pushed record so no extra cycle is spent latching it.
  assign push_rec = '{addr: {addr_hi, addr_mid, in_data}, frac: frac, vol_l: vol_l, vol_r: vol_r};

  always_comb begin
    nxt_mix_idx  = mix_idx;
    nxt_addr_idx = addr_idx;
    nxt_mix_done = mix_done;
    nxt_frac     = frac;
    nxt_vol_l    = vol_l;
    nxt_vol_r    = vol_r;
    nxt_addr_hi  = addr_hi;
    nxt_addr_mid = addr_mid;
    push         = 1'b0;
    seq_err_set  = 1'b0;
    // Frame start restarts assembly first, so a coincident strobe lands at index 0.
    if (sync_stb) begin
      seq_err_set  = (mix_idx != BYTE_FIRST) || (addr_idx != BYTE_FIRST) || mix_done;
      nxt_mix_idx  = BYTE_FIRST;
      nxt_addr_idx = BYTE_FIRST;
      nxt_mix_done = 1'b0;
    end
    if (in_stb_addr && in_stb_mix) begin
      seq_err_set = 1'b1;
    end else if (in_stb_mix) begin
      if (nxt_mix_done) begin
        seq_err_set  = 1'b1;
        nxt_mix_done = 1'b0;
      end
      case (nxt_mix_idx)
        BYTE_FIRST: begin
          nxt_frac    = in_data;
          nxt_mix_idx = BYTE_SECOND;
        end
        BYTE_SECOND: begin
          nxt_vol_l   = in_data[5:0];
          nxt_mix_idx = BYTE_THIRD;
        end
        BYTE_THIRD: begin
          nxt_vol_r    = in_data[5:0];
          nxt_mix_done = 1'b1;
          nxt_mix_idx  = BYTE_FIRST;
        end
        default: nxt_mix_idx = BYTE_FIRST;
      endcase
    end else if (in_stb_addr) begin
      case (nxt_addr_idx)
        BYTE_FIRST: begin
          nxt_addr_hi  = in_data[5:0];
          nxt_addr_idx = BYTE_SECOND;
        end
        BYTE_SECOND: begin
          nxt_addr_mid = in_data;
          nxt_addr_idx = BYTE_THIRD;
        end
        BYTE_THIRD: begin
          push         = nxt_mix_done;
          seq_err_set  = seq_err_set || !nxt_mix_done;
          nxt_mix_done = 1'b0;
          nxt_addr_idx = BYTE_FIRST;
        end
        default: nxt_addr_idx = BYTE_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_idx  <= BYTE_FIRST;
      addr_idx <= BYTE_FIRST;
      mix_done <= 1'b0;
      frac     <= '0;
      vol_l    <= '0;
      vol_r    <= '0;
      addr_hi  <= '0;
      addr_mid <= '0;
      ovf      <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      mix_idx  <= nxt_mix_idx;
      addr_idx <= nxt_addr_idx;
      mix_done <= nxt_mix_done;
      frac     <= nxt_frac;
      vol_l    <= nxt_vol_l;
      vol_r    <= nxt_vol_r;
      addr_hi  <= nxt_addr_hi;
      addr_mid <= nxt_addr_mid;
      ovf      <= ovf_set || (ovf && !err_clr);
      seq_err  <= seq_err_set || (seq_err && !err_clr);
    end
  end

  assign ovf_set = push && fifo_full && !rec_ready;

  rec_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH),
    .CNTW (CNTW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (rec_ready),
    .wdata(push_rec),
    .rdata(head_rec),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(rec_count)
  );

  assign rec_valid = !fifo_empty;
  assign rec_addr  = head_rec.addr;
  assign rec_frac  = head_rec.frac;
  assign rec_vol_l = head_rec.vol_l;
  assign rec_vol_r = head_rec.vol_r;

endmodule
